// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: elastic valid/ready pipeline register.
// A chain of STAGES skid-buffered stages carries a WIDTH-bit payload at full
// throughput under back-pressure. Every ready signal comes from a flop, so no
// combinational path runs from out_ready back to in_ready. The block also has a
// synchronous flush and a registered occupancy count.
module pipe_skid_reg #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int CNTW   = $clog2(2*STAGES+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNTW-1:0]  count
);

  // Per-stage state: main entry (mv/md) and skid entry (sv/sd).
  logic [STAGES-1:0] mv_q, mv_d;
  logic [STAGES-1:0] sv_q, sv_d;
  logic [WIDTH-1:0]  md_q [STAGES];
  logic [WIDTH-1:0]  md_d [STAGES];
  logic [WIDTH-1:0]  sd_q [STAGES];
  logic [WIDTH-1:0]  sd_d [STAGES];
  logic [CNTW-1:0]   count_q, count_d;

  // Handshake nets between neighbouring stages.
  logic [STAGES-1:0] up_valid;
  logic [STAGES-1:0] up_ready;
  logic [STAGES-1:0] dn_ready;
  logic [STAGES-1:0] acc;
  logic [STAGES-1:0] emit;
  logic [WIDTH-1:0]  up_data [STAGES];

  // Stage-to-stage wiring: stage i's downstream handshake is stage i+1's upstream.
  always_comb begin
    up_valid[0] = in_valid;
    up_data[0]  = in_data;
    for (int i = 1; i < STAGES; i++) begin
      up_valid[i] = mv_q[i-1];
      up_data[i]  = md_q[i-1];
    end
    // A stage stays ready as long as its skid register is free.
    up_ready = ~sv_q;
    dn_ready[STAGES-1] = out_ready;
    for (int i = 0; i < STAGES-1; i++) begin
      dn_ready[i] = up_ready[i+1];
    end
    acc  = up_valid & up_ready;
    emit = mv_q & dn_ready;
  end

  // Next-state logic for every stage. Flush overrides everything else.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    mv_d = mv_q;
    sv_d = sv_q;
    md_d = md_q;
    sd_d = sd_q;
    for (int i = 0; i < STAGES; i++) begin
      if (!mv_q[i] || emit[i]) begin
        // The main slot frees up. Refill it from the skid first, then from upstream.
        if (sv_q[i]) begin
          mv_d[i] = 1'b1;
          md_d[i] = sd_q[i];
        end else if (acc[i]) begin
          mv_d[i] = 1'b1;
          md_d[i] = up_data[i];
        end else begin
          mv_d[i] = 1'b0;
        end
        sv_d[i] = 1'b0;
      end else if (acc[i]) begin
        // Main is stalled, so the skid catches the entry accepted this cycle.
        sv_d[i] = 1'b1;
        sd_d[i] = up_data[i];
      end
    end
    if (flush) begin
      mv_d = '0;
      sv_d = '0;
      for (int i = 0; i < STAGES; i++) begin
        md_d[i] = '0;
        sd_d[i] = '0;
      end
    end
  end

  // Occupancy after this edge: number of valid main and skid entries.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < STAGES; i++) begin
      count_d = count_d + CNTW'(mv_d[i]) + CNTW'(sv_d[i]);
    end
  end

  // State registers. An asynchronous reset clears valids, payloads and the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mv_q    <= '0;
      sv_q    <= '0;
      count_q <= '0;
      // NOTE: the payload arrays are small register banks, not RAM, so they are reset; this keeps out_data at 0 after reset.
      for (int i = 0; i < STAGES; i++) begin
        md_q[i] <= '0;
        sd_q[i] <= '0;
      end
    end else begin
      // NOTE: state registers use non-blocking assignments, so every stage samples its neighbours' pre-edge values.
      mv_q    <= mv_d;
      sv_q    <= sv_d;
      md_q    <= md_d;
      sd_q    <= sd_d;
      count_q <= count_d;
    end
  end

  assign in_ready  = up_ready[0];
  assign out_valid = mv_q[STAGES-1];
  assign out_data  = md_q[STAGES-1];
  assign count     = count_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Testbench for pipe_skid_reg (WIDTH=32, STAGES=2).
// A scoreboard queue holds every accepted entry and is checked against each
// emitted entry. A table of vectors covers the stall-fill sequence, and short
// hand-written sequences cover reset, streaming, flush and random traffic.
module tb_pipe_skid_reg;

  localparam int W  = 32;
  localparam int S  = 2;
  localparam int CW = $clog2(2*S+1);

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] count;

  pipe_skid_reg #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_vec = 0;
  int           n_bad = 0;
  logic [W-1:0] sb [$];
  int           cyc = 0;
  // Streaming latency and gap tracking.
  logic         track = 1'b0;
  int           first_acc;
  int           last_emit;
  int           n_emit;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive the inputs for one cycle, sample on the falling edge, update the scoreboard,
  // then advance to just after the next rising edge.
  task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl,
                      output logic accepted, output logic s_ir, output logic s_ov,
                      output logic [CW-1:0] s_cnt);
    logic [W-1:0] exp_d;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    s_ir  = in_ready;
    s_ov  = out_valid;
    s_cnt = count;
    accepted = in_valid && in_ready;
    check("count_vs_model", 64'(count), 64'(sb.size()));
    if (sb.size() == 2*S) check("full_blocks_input", 64'(in_ready), 64'd0);
    if (sb.size() == 0)   check("empty_no_valid", 64'(out_valid), 64'd0);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("emit_from_empty_model", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_d = sb.pop_front();
        check("out_data_order", 64'(out_data), 64'(exp_d));
      end
      if (track) begin
        if (n_emit == 0) check("stream_latency", 64'(cyc - first_acc), 64'd2);
        else             check("stream_gap", 64'(cyc - last_emit), 64'd1);
        last_emit = cyc;
        n_emit++;
      end
    end
    if (fl) begin
      sb.delete();
    end else if (accepted) begin
      sb.push_back(in_data);
      if (track && first_acc < 0) first_acc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int budget);
    logic a, ir, ov;
    logic [CW-1:0] c;
    for (int k = 0; k < budget && sb.size() > 0; k++) begin
      step(1'b0, '0, 1'b1, 1'b0, a, ir, ov, c);
    end
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  typedef struct {
    logic          iv;
    logic [W-1:0]  d;
    logic          ordy;
    logic          exp_ir;
    logic          exp_ov;
    logic [CW-1:0] exp_cnt;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic a, ir, ov;
    logic [CW-1:0] c;
    int pushed;
    int guard;

    // Stall fill and release, starting from an empty chain. Expected values are the
    // state sampled before each step's edge.
    tbl[0] = '{1'b1, 32'hA0, 1'b0, 1'b1, 1'b0, 3'd0};
    tbl[1] = '{1'b1, 32'hA1, 1'b0, 1'b1, 1'b0, 3'd1};
    tbl[2] = '{1'b1, 32'hA2, 1'b0, 1'b1, 1'b1, 3'd2};
    tbl[3] = '{1'b1, 32'hA3, 1'b0, 1'b1, 1'b1, 3'd3};
    tbl[4] = '{1'b1, 32'hA4, 1'b0, 1'b0, 1'b1, 3'd4};
    tbl[5] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 3'd4};
    tbl[6] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 3'd3};
    tbl[7] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 3'd2};
    tbl[8] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 3'd1};
    tbl[9] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 3'd0};

    // Reset held for 3 cycles while the producer presents data.
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hDEADBEEF;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, a, ir, ov, c);
    check("post_reset_accept", 64'(a), 64'd1);
    drain(20);

    // Back-to-back streaming of 0x1..0x10 with the consumer always ready.
    track = 1'b1;
    first_acc = -1;
    n_emit = 0;
    for (int v = 1; v <= 16; v++) begin
      step(1'b1, W'(v), 1'b1, 1'b0, a, ir, ov, c);
      check("stream_accept", 64'(a), 64'd1);
    end
    drain(20);
    check("stream_emit_count", 64'(n_emit), 64'd16);
    track = 1'b0;

    // Table-driven stall fill, then release.
    for (int k = 0; k < 10; k++) begin
      step(tbl[k].iv, tbl[k].d, tbl[k].ordy, 1'b0, a, ir, ov, c);
      check($sformatf("tbl%0d_in_ready", k), 64'(ir), 64'(tbl[k].exp_ir));
      check($sformatf("tbl%0d_out_valid", k), 64'(ov), 64'(tbl[k].exp_ov));
      check($sformatf("tbl%0d_count", k), 64'(c), 64'(tbl[k].exp_cnt));
    end

    // Random back-pressure with 1000 entries.
    pushed = 0;
    guard  = 0;
    while (pushed < 1000 && guard < 20000) begin
      step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)), 1'b0, a, ir, ov, c);
      if (a) pushed++;
      guard++;
    end
    check("random_pushed", 64'(pushed), 64'd1000);
    drain(50);

    // Flush with three entries held, while the producer offers 0x55.
    for (int k = 0; k < 3; k++) step(1'b1, W'(32'h30 + k), 1'b0, 1'b0, a, ir, ov, c);
    check("pre_flush_count", 64'(count), 64'd3);
    step(1'b1, 32'h55, 1'b0, 1'b1, a, ir, ov, c);
    check("flush_count", 64'(count), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_out_data", 64'(out_data), 64'd0);
    for (int k = 0; k < 4; k++) step(1'b1, W'(32'h60 + k), 1'b1, 1'b0, a, ir, ov, c);
    drain(20);

    // Asynchronous reset pulse while the chain is full.
    guard = 0;
    do begin
      step(1'b1, W'(32'hC0 + guard), 1'b0, 1'b0, a, ir, ov, c);
      guard++;
    end while (ir && guard < 20);
    check("fill_before_reset", 64'(count), 64'(2*S));
    #1 rst = 1'b1;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_count", 64'(count), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    #1 rst = 1'b0;
    sb.delete();
    for (int k = 0; k < 8; k++) begin
      step(1'b1, W'(32'hE0 + k), 1'b1, 1'b0, a, ir, ov, c);
      check("resume_accept", 64'(a), 64'd1);
    end
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
